// File: rtl/uart_rxtx_if.sv
// ============================================================================
// Module      : uart_rxtx_if
// Description : CPU-side register bus of uart_rxtx (write/read strobes, status).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_rxtx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] wdata;
  logic                 we;
  logic                 tx_busy;
  logic [DATA_BITS-1:0] rdata;
  logic                 rx_valid;
  logic                 re;
  logic                 rx_overrun;
  logic                 rx_frame_err;
  logic                 rx_parity_err;

  modport master (
    output wdata, we, re,
    input  tx_busy, rdata, rx_valid, rx_overrun, rx_frame_err, rx_parity_err
  );

  modport slave (
    input  wdata, we, re,
    output tx_busy, rdata, rx_valid, rx_overrun, rx_frame_err, rx_parity_err
  );
endinterface

`default_nettype wire

// File: rtl/uart_rxtx.sv
// ============================================================================
// Module      : uart_rxtx
// Description : Full-duplex UART, DIVISOR clocks per bit, mid-bit RX sampling.
//               Optional even parity enabled by defining UART_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rxtx #(
  parameter int DIVISOR   = 416,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  wire        clk,
  input  wire        rst_n,
  uart_rxtx_if.slave bus,
  output logic       tx,
  input  wire        rx
);

  localparam logic [15:0] C_DIV_LAST  = 16'(DIVISOR - 1);
  localparam logic [15:0] C_DIV_HALF  = 16'(DIVISOR / 2);
  localparam logic [3:0]  C_DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]  C_STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

  // ---------------- transmitter ----------------
  state_t               r_tx_state;
  logic [15:0]          r_tx_cnt;
  logic [3:0]           r_tx_bit;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic                 r_tx;
  logic                 r_tx_busy;
`ifdef UART_PARITY_EN
  logic                 r_tx_par;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= ST_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx       <= 1'b1;
      r_tx_busy  <= 1'b0;
`ifdef UART_PARITY_EN
      r_tx_par   <= 1'b0;
`endif
    end else begin
      case (r_tx_state)
        ST_IDLE: begin
          if (bus.we) begin
            r_tx_state <= ST_START;
            r_tx_shift <= bus.wdata;
`ifdef UART_PARITY_EN
            r_tx_par   <= ^bus.wdata;
`endif
            r_tx       <= 1'b0;
            r_tx_busy  <= 1'b1;
            r_tx_cnt   <= '0;
          end
        end
        default: begin
          if (r_tx_cnt != C_DIV_LAST) begin
            r_tx_cnt <= r_tx_cnt + 16'd1;
          end else begin
            // Bit boundary: counter restarts so every bit is exactly DIVISOR clocks
            r_tx_cnt <= '0;
            case (r_tx_state)
              ST_START: begin
                r_tx_state <= ST_DATA;
                r_tx       <= r_tx_shift[0];
                r_tx_bit   <= '0;
              end
              ST_DATA: begin
                if (r_tx_bit == C_DATA_LAST) begin
                  r_tx_bit   <= '0;
`ifdef UART_PARITY_EN
                  r_tx_state <= ST_PARITY;
                  r_tx       <= r_tx_par;
`else
                  r_tx_state <= ST_STOP;
                  r_tx       <= 1'b1;
`endif
                end else begin
                  r_tx_shift <= r_tx_shift >> 1;
                  r_tx       <= r_tx_shift[1];
                  r_tx_bit   <= r_tx_bit + 4'd1;
                end
              end
`ifdef UART_PARITY_EN
              ST_PARITY: begin
                r_tx_state <= ST_STOP;
                r_tx       <= 1'b1;
              end
`endif
              ST_STOP: begin
                if (r_tx_bit == C_STOP_LAST) begin
                  r_tx_state <= ST_IDLE;
                  r_tx_busy  <= 1'b0;
                end else begin
                  r_tx_bit <= r_tx_bit + 4'd1;
                end
              end
              default: begin
                r_tx_state <= ST_IDLE;
                r_tx       <= 1'b1;
                r_tx_busy  <= 1'b0;
              end
            endcase
          end
        end
      endcase
    end
  end

  // ---------------- receiver ----------------
  logic r_rx_meta, r_rx_sync, r_rx_prev;
  logic w_rx_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  assign w_rx_fall = r_rx_prev & ~r_rx_sync;

  state_t               r_rx_state;
  logic [15:0]          r_rx_cnt;
  logic [3:0]           r_rx_bit;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic [DATA_BITS-1:0] r_rdata;
  logic                 r_rx_valid;
  logic                 r_rx_overrun;
  logic                 r_rx_frame_err;
`ifdef UART_PARITY_EN
  logic                 r_rx_par;
  logic                 r_rx_parity_err;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state      <= ST_IDLE;
      r_rx_cnt        <= '0;
      r_rx_bit        <= '0;
      r_rx_shift      <= '0;
      r_rdata         <= '0;
      r_rx_valid      <= 1'b0;
      r_rx_overrun    <= 1'b0;
      r_rx_frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
      r_rx_par        <= 1'b0;
      r_rx_parity_err <= 1'b0;
`endif
    end else begin
      if (bus.re) begin
        r_rx_valid   <= 1'b0;
        r_rx_overrun <= 1'b0;
      end
      case (r_rx_state)
        ST_IDLE: begin
          if (w_rx_fall) begin
            r_rx_state <= ST_START;
            r_rx_cnt   <= '0;
          end
        end
        ST_START: begin
          if (r_rx_cnt == C_DIV_HALF) begin
            r_rx_cnt <= '0;
            r_rx_bit <= '0;
            // A line already back high at mid-start was a glitch
            r_rx_state <= r_rx_sync ? ST_IDLE : ST_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (r_rx_cnt == C_DIV_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
            r_rx_bit   <= r_rx_bit + 4'd1;
            if (r_rx_bit == C_DATA_LAST) begin
`ifdef UART_PARITY_EN
              r_rx_state <= ST_PARITY;
`else
              r_rx_state <= ST_STOP;
`endif
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
          end
        end
`ifdef UART_PARITY_EN
        ST_PARITY: begin
          if (r_rx_cnt == C_DIV_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_par   <= r_rx_sync;
            r_rx_state <= ST_STOP;
          end else begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
          end
        end
`endif
        ST_STOP: begin
          if (r_rx_cnt == C_DIV_LAST) begin
            // Back to IDLE on the stop sample so a following frame is not missed
            r_rx_cnt       <= '0;
            r_rx_state     <= ST_IDLE;
            r_rdata        <= r_rx_shift;
            r_rx_valid     <= 1'b1;
            r_rx_frame_err <= ~r_rx_sync;
`ifdef UART_PARITY_EN
            r_rx_parity_err <= (^r_rx_shift) ^ r_rx_par;
`endif
            if (r_rx_valid && !bus.re) begin
              r_rx_overrun <= 1'b1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
          end
        end
        default: r_rx_state <= ST_IDLE;
      endcase
    end
  end

  assign tx               = r_tx;
  assign bus.tx_busy      = r_tx_busy;
  assign bus.rdata        = r_rdata;
  assign bus.rx_valid     = r_rx_valid;
  assign bus.rx_overrun   = r_rx_overrun;
  assign bus.rx_frame_err = r_rx_frame_err;
`ifdef UART_PARITY_EN
  assign bus.rx_parity_err = r_rx_parity_err;
`else
  assign bus.rx_parity_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rxtx.sv
// ============================================================================
// Module      : tb_uart_rxtx
// Description : Directed bench for uart_rxtx at DIVISOR=8, 8 data bits, 1 stop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rxtx;
  localparam int D = 8;
`ifdef UART_PARITY_EN
  localparam int NB       = 11;
  localparam bit C_PAR_EN = 1'b1;
`else
  localparam int NB       = 10;
  localparam bit C_PAR_EN = 1'b0;
`endif

  logic clk     = 1'b0;
  logic rst_n   = 1'b1;
  logic rx_drv  = 1'b1;
  logic loop_en = 1'b0;
  logic tx_w;
  logic rx_line;
  logic rx_ok;
  logic [10:0] fb;

  assign rx_line = loop_en ? tx_w : rx_drv;

  uart_rxtx_if #(.DATA_BITS(8)) bus ();

  uart_rxtx #(.DIVISOR(D), .DATA_BITS(8), .STOP_BITS(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .tx    (tx_w),
    .rx    (rx_line)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_valid(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.rx_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_re();
    bus.re = 1'b1;
    @(negedge clk);
    bus.re = 1'b0;
  endtask

  // Serial frame onto rx, then two idle bit times
  task automatic drive_frame(input logic [7:0] d, input logic stop, input logic par);
    rx_drv = 1'b0;
    repeat (D) @(negedge clk);
    for (int b = 0; b < 8; b++) begin
      rx_drv = d[b];
      repeat (D) @(negedge clk);
    end
    if (C_PAR_EN) begin
      rx_drv = par;
      repeat (D) @(negedge clk);
    end
    rx_drv = stop;
    repeat (D) @(negedge clk);
    rx_drv = 1'b1;
    repeat (2 * D) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       flip;
    logic       re_before;
    logic [7:0] exp_rdata;
    logic       exp_ferr;
    logic       exp_ovr;
    logic       exp_perr;
  } rxvec_t;

  rxvec_t vt [5];

  initial begin
    bus.wdata = 8'h00;
    bus.we    = 1'b0;
    bus.re    = 1'b0;

    vt[0] = '{8'h55, 1'b0, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0};
    vt[1] = '{8'h07, 1'b1, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0, C_PAR_EN};
    vt[2] = '{8'hA0, 1'b1, 1'b0, 1'b1, 8'hA0, 1'b0, 1'b0, 1'b0};
    vt[3] = '{8'h11, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0};
    vt[4] = '{8'h22, 1'b1, 1'b0, 1'b0, 8'h22, 1'b0, 1'b1, 1'b0};

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx_w, 1);
    chk("rst_busy", bus.tx_busy, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_valid", bus.rx_valid, 0);
    chk("rst_ovr", bus.rx_overrun, 0);
    chk("rst_ferr", bus.rx_frame_err, 0);
    chk("rst_perr", bus.rx_parity_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // TX waveform of 0xA5; a write at sample 20 must be ignored
    fb = C_PAR_EN ? {1'b1, 1'b0, 8'hA5, 1'b0} : {1'b0, 1'b1, 8'hA5, 1'b0};
    bus.wdata = 8'hA5;
    bus.we    = 1'b1;
    for (int i = 0; i < NB * D; i++) begin
      @(negedge clk);
      if (i == 0) bus.we = 1'b0;
      chk("tx_bit", tx_w, fb[i / D]);
      chk("tx_busy_hi", bus.tx_busy, 1);
      if (i == 20) begin
        bus.wdata = 8'hFF;
        bus.we    = 1'b1;
      end
      if (i == 21) bus.we = 1'b0;
    end
    @(negedge clk);
    chk("tx_busy_end", bus.tx_busy, 0);
    chk("tx_idle_end", tx_w, 1);

    if (C_PAR_EN) begin
      bus.wdata = 8'h07;
      bus.we    = 1'b1;
      for (int i = 0; i < NB * D; i++) begin
        @(negedge clk);
        if (i == 0) bus.we = 1'b0;
        if (i == 9 * D + D / 2) chk("tx_parity_bit", tx_w, 1);
      end
      repeat (2) @(negedge clk);
    end

    // Loopback, two frames back to back
    loop_en = 1'b1;
    repeat (2) @(negedge clk);
    fork
      begin
        int cnt;
        cnt = 0;
        bus.wdata = 8'h3C;
        bus.we    = 1'b1;
        @(negedge clk);
        bus.we = 1'b0;
        while (bus.tx_busy && cnt < 200) begin
          cnt++;
          @(negedge clk);
        end
        chk("lb_busy_cycles", cnt, NB * D);
        chk("lb_tx_high_at_fall", tx_w, 1);
        bus.wdata = 8'hC3;
        bus.we    = 1'b1;
        @(negedge clk);
        bus.we = 1'b0;
      end
      begin
        for (int k = 0; k < 2; k++) begin
          wait_valid(rx_ok);
          chk("lb_valid", rx_ok, 1);
          chk("lb_rdata", bus.rdata, (k == 0) ? 8'h3C : 8'hC3);
          chk("lb_ferr", bus.rx_frame_err, 0);
          chk("lb_ovr", bus.rx_overrun, 0);
          chk("lb_perr", bus.rx_parity_err, 0);
          pulse_re();
        end
      end
    join
    repeat (3 * D) @(negedge clk);
    loop_en = 1'b0;
    repeat (2 * D) @(negedge clk);

    // Table-driven receive frames
    for (int v = 0; v < 5; v++) begin
      if (vt[v].re_before) pulse_re();
      drive_frame(vt[v].data, vt[v].stop, (^vt[v].data) ^ vt[v].flip);
      chk("rx_rdata", bus.rdata, vt[v].exp_rdata);
      chk("rx_valid", bus.rx_valid, 1);
      chk("rx_ferr", bus.rx_frame_err, vt[v].exp_ferr);
      chk("rx_ovr", bus.rx_overrun, vt[v].exp_ovr);
      chk("rx_perr", bus.rx_parity_err, vt[v].exp_perr);
    end

    pulse_re();
    chk("re_clr_valid", bus.rx_valid, 0);
    chk("re_clr_ovr", bus.rx_overrun, 0);
    chk("re_keep_rdata", bus.rdata, 8'h22);
    pulse_re();
    chk("re_idle_valid", bus.rx_valid, 0);
    chk("re_idle_rdata", bus.rdata, 8'h22);

    // Two-cycle glitch, then a clean frame
    rx_drv = 1'b0;
    repeat (2) @(negedge clk);
    rx_drv = 1'b1;
    repeat (3 * D) @(negedge clk);
    chk("glitch_valid", bus.rx_valid, 0);
    chk("glitch_rdata", bus.rdata, 8'h22);
    drive_frame(8'h55, 1'b1, 1'b0);
    chk("post_glitch_rdata", bus.rdata, 8'h55);
    chk("post_glitch_valid", bus.rx_valid, 1);
    chk("post_glitch_ferr", bus.rx_frame_err, 0);

    // Reset in the middle of a transmit frame
    bus.wdata = 8'h0F;
    bus.we    = 1'b1;
    @(negedge clk);
    bus.we = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_tx", tx_w, 0);
    chk("pre_rst_busy", bus.tx_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_tx", tx_w, 1);
    chk("async_rst_busy", bus.tx_busy, 0);
    chk("async_rst_valid", bus.rx_valid, 0);
    chk("async_rst_rdata", bus.rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * D) @(negedge clk);
    chk("no_resume_tx", tx_w, 1);
    chk("no_resume_busy", bus.tx_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
